// File: rtl/i2c_passthru_pkg.sv
// rtl/i2c_passthru_pkg.sv - shared types and constants for the I2C passthrough arbiter
// Purpose: arbiter state encoding and the grant statistics counter width.
// Ports: none (package).
package i2c_passthru_pkg;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_OWN_A      = 3'd1,
    ST_OWN_B      = 3'd2,
    ST_DISCONNECT = 3'd3,
    ST_HOLDOFF    = 3'd4
  } arb_state_e;

  localparam int STATS_CNT_W = 16;

endpackage

// File: rtl/i2c_passthru_mst_arb_if.sv
// rtl/i2c_passthru_mst_arb_if.sv - bus/control bundle between the passthrough core and its arbiter
// Purpose: groups filtered SCL/SDA of both channels, idle/violation/stuck status,
//          the f_ref timing reference and the ownership controls.
// Modports: slv - arbiter side (status in, controls out)
//           mst - environment side (drives status, observes controls)
interface i2c_passthru_mst_arb_if;

  logic i_f_ref;
  logic i_cha_scl;
  logic i_cha_sda;
  logic i_chb_scl;
  logic i_chb_sda;
  logic i_cha_idle;
  logic i_chb_idle;
  logic i_violation;
  logic i_stuck;
  logic o_cha_ismst;
  logic o_chb_ismst;
  logic o_disconnect;
  logic o_start;
  logic o_txn_done;
  logic o_tie;

  modport slv (
    input  i_f_ref, i_cha_scl, i_cha_sda, i_chb_scl, i_chb_sda,
    input  i_cha_idle, i_chb_idle, i_violation, i_stuck,
    output o_cha_ismst, o_chb_ismst, o_disconnect, o_start, o_txn_done, o_tie
  );

  modport mst (
    output i_f_ref, i_cha_scl, i_cha_sda, i_chb_scl, i_chb_sda,
    output i_cha_idle, i_chb_idle, i_violation, i_stuck,
    input  o_cha_ismst, o_chb_ismst, o_disconnect, o_start, o_txn_done, o_tie
  );

endinterface

// File: rtl/i2c_passthru_startstop_det.sv
// rtl/i2c_passthru_startstop_det.sv - START/STOP detector for one I2C channel
// Purpose: keeps the previous SCL/SDA sample and flags START (SDA falls while
//          SCL stays high) and STOP (SDA rises while SCL stays high).
// Ports: i_clk, i_rstn (async active-low), i_scl, i_sda (filtered lines),
//        o_start, o_stop (combinational pulses, valid for the current sample).
module i2c_passthru_startstop_det (
  input  logic i_clk,
  input  logic i_rstn,
  input  logic i_scl,
  input  logic i_sda,
  output logic o_start,
  output logic o_stop
);

  logic prev_scl;
  logic prev_sda;

  // Lines idle high, so reset the history to 1 to avoid a false event on release.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      prev_scl <= 1'b1;
      prev_sda <= 1'b1;
    end else begin
      prev_scl <= i_scl;
      prev_sda <= i_sda;
    end
  end

  assign o_start = prev_sda & ~i_sda & i_scl & prev_scl;
  assign o_stop  = ~prev_sda & i_sda & i_scl & prev_scl;

endmodule

// File: rtl/i2c_passthru_mst_arb.sv
// rtl/i2c_passthru_mst_arb.sv - master-ownership arbiter for the two-channel I2C passthrough
// Purpose: grants bus ownership to one channel per transaction, enforces the
//          t_buf bus-free holdoff and revokes ownership on violation/stuck.
// Ports: i_clk, i_rstn (async active-low), bus (i2c_passthru_mst_arb_if.slv).
// Optional: I2C_PASSTHRU_ARB_STATS_EN adds i_stats_clr, o_grant_cnt_a, o_grant_cnt_b.
module i2c_passthru_mst_arb
  import i2c_passthru_pkg::*;
#(
  parameter int F_REF_T_BUF       = 38,
  parameter int WIDTH_F_REF_T_BUF = 6,
  parameter bit PRIORITY_A        = 1'b1
) (
  input  logic                   i_clk,
  input  logic                   i_rstn,
`ifdef I2C_PASSTHRU_ARB_STATS_EN
  input  logic                   i_stats_clr,
  output logic [STATS_CNT_W-1:0] o_grant_cnt_a,
  output logic [STATS_CNT_W-1:0] o_grant_cnt_b,
`endif
  i2c_passthru_mst_arb_if.slv    bus
);

  localparam logic [WIDTH_F_REF_T_BUF-1:0] TBUF_MAX = WIDTH_F_REF_T_BUF'(F_REF_T_BUF);

  arb_state_e                   state_q, state_d;
  logic [WIDTH_F_REF_T_BUF-1:0] cnt_q, cnt_d;
  logic fref_q, idle_a_q, idle_b_q;
  logic cha_q, chb_q, disc_q, start_q, done_q, tie_q;
  logic cha_d, chb_d, disc_d, start_d, done_d, tie_d;
  logic start_a, stop_a, start_b, stop_b;
  logic grant_a, grant_b;
  logic fref_rise, idle_a_rise, idle_b_rise, lines_high;

  i2c_passthru_startstop_det u_det_a (
    .i_clk  (i_clk),
    .i_rstn (i_rstn),
    .i_scl  (bus.i_cha_scl),
    .i_sda  (bus.i_cha_sda),
    .o_start(start_a),
    .o_stop (stop_a)
  );

  i2c_passthru_startstop_det u_det_b (
    .i_clk  (i_clk),
    .i_rstn (i_rstn),
    .i_scl  (bus.i_chb_scl),
    .i_sda  (bus.i_chb_sda),
    .o_start(start_b),
    .o_stop (stop_b)
  );

  assign fref_rise   = bus.i_f_ref & ~fref_q;
  // Idle history resets high so an already-idle channel does not look like a timeout.
  assign idle_a_rise = bus.i_cha_idle & ~idle_a_q;
  assign idle_b_rise = bus.i_chb_idle & ~idle_b_q;
  assign lines_high  = bus.i_cha_scl & bus.i_cha_sda & bus.i_chb_scl & bus.i_chb_sda;

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      fref_q   <= 1'b0;
      idle_a_q <= 1'b1;
      idle_b_q <= 1'b1;
      cha_q    <= 1'b0;
      chb_q    <= 1'b0;
      disc_q   <= 1'b0;
      start_q  <= 1'b0;
      done_q   <= 1'b0;
      tie_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      fref_q   <= bus.i_f_ref;
      idle_a_q <= bus.i_cha_idle;
      idle_b_q <= bus.i_chb_idle;
      cha_q    <= cha_d;
      chb_q    <= chb_d;
      disc_q   <= disc_d;
      start_q  <= start_d;
      done_q   <= done_d;
      tie_q    <= tie_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = '0;
    cha_d   = 1'b0;
    chb_d   = 1'b0;
    disc_d  = 1'b0;
    start_d = 1'b0;
    done_d  = 1'b0;
    tie_d   = 1'b0;
    grant_a = 1'b0;
    grant_b = 1'b0;

    case (state_q)
      ST_IDLE: begin
        // A same-cycle tie is resolved by priority regardless of idle status.
        if (start_a && start_b) begin
          tie_d = 1'b1;
          if (PRIORITY_A) grant_a = 1'b1;
          else            grant_b = 1'b1;
        end else if (start_a && bus.i_chb_idle) begin
          grant_a = 1'b1;
        end else if (start_b && bus.i_cha_idle) begin
          grant_b = 1'b1;
        end
        if (grant_a) begin
          state_d = ST_OWN_A;
          cha_d   = 1'b1;
          start_d = 1'b1;
        end else if (grant_b) begin
          state_d = ST_OWN_B;
          chb_d   = 1'b1;
          start_d = 1'b1;
        end
      end

      ST_OWN_A: begin
        if (bus.i_violation || bus.i_stuck) begin
          state_d = ST_DISCONNECT;
          disc_d  = 1'b1;
        end else if (stop_a || idle_a_rise) begin
          state_d = ST_HOLDOFF;
          done_d  = 1'b1;
        end else begin
          cha_d = 1'b1;
        end
      end

      ST_OWN_B: begin
        if (bus.i_violation || bus.i_stuck) begin
          state_d = ST_DISCONNECT;
          disc_d  = 1'b1;
        end else if (stop_b || idle_b_rise) begin
          state_d = ST_HOLDOFF;
          done_d  = 1'b1;
        end else begin
          chb_d = 1'b1;
        end
      end

      ST_DISCONNECT: begin
        if (bus.i_cha_idle && bus.i_chb_idle && !bus.i_stuck) begin
          state_d = ST_HOLDOFF;
        end else begin
          disc_d = 1'b1;
        end
      end

      ST_HOLDOFF: begin
        if (bus.i_stuck) begin
          state_d = ST_DISCONNECT;
          disc_d  = 1'b1;
        end else if (cnt_q == TBUF_MAX) begin
          state_d = ST_IDLE;
        end else if (!lines_high) begin
          cnt_d = '0;
        end else if (fref_rise) begin
          cnt_d = cnt_q + 1'b1;
        end else begin
          cnt_d = cnt_q;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  assign bus.o_cha_ismst  = cha_q;
  assign bus.o_chb_ismst  = chb_q;
  assign bus.o_disconnect = disc_q;
  assign bus.o_start      = start_q;
  assign bus.o_txn_done   = done_q;
  assign bus.o_tie        = tie_q;

`ifdef I2C_PASSTHRU_ARB_STATS_EN
  // Clear has priority over a coincident grant; counters saturate at all-ones.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      o_grant_cnt_a <= '0;
      o_grant_cnt_b <= '0;
    end else if (i_stats_clr) begin
      o_grant_cnt_a <= '0;
      o_grant_cnt_b <= '0;
    end else begin
      if (grant_a && (o_grant_cnt_a != '1)) o_grant_cnt_a <= o_grant_cnt_a + 1'b1;
      if (grant_b && (o_grant_cnt_b != '1)) o_grant_cnt_b <= o_grant_cnt_b + 1'b1;
    end
  end
`endif

endmodule

// File: doc/i2c_passthru_mst_arb.md
Name: i2c_passthru_mst_arb

Overview:
Bus-ownership arbiter for the two-channel I2C passthrough core. Watches filtered SCL/SDA on channel a and channel b and detects START/STOP on each. Grants master ownership to exactly one channel per transaction and drives the ismst/disconnect controls that steer the bitrx/bittx datapath. After each transaction it enforces a t_buf bus-free holdoff, and it revokes ownership on violation or stuck conditions.

Parameters:
F_REF_T_BUF, 38, number of i_f_ref rising edges with both buses fully released before a new grant (t_buf)
WIDTH_F_REF_T_BUF, 6, CEILING(LOG2(F_REF_T_BUF+1))
PRIORITY_A, 1, 1 = channel a wins a same-cycle START tie; 0 = channel b wins

Ports:
i_clk  in  1  system clock
i_rstn  in  1  reset, asynchronous, active-low
i_f_ref  in  1  timing reference; its rising edges (detected internally in i_clk domain) are counted
i_cha_scl  in  1  filtered channel a SCL
i_cha_sda  in  1  filtered channel a SDA
i_chb_scl  in  1  filtered channel b SCL
i_chb_sda  in  1  filtered channel b SDA
i_cha_idle  in  1  channel a idle (from idle/stuck block)
i_chb_idle  in  1  channel b idle
i_violation  in  1  bit violation from bitrx or bittx (level)
i_stuck  in  1  either channel stuck (level)
o_cha_ismst  out  1  channel a owns the bus
o_chb_ismst  out  1  channel b owns the bus
o_disconnect  out  1  datapath held in reset; both channels released
o_start  out  1  one-clock pulse when a grant is issued
o_txn_done  out  1  one-clock pulse when the owner ends its transaction by STOP or idle timeout
o_tie  out  1  one-clock pulse when STARTs on both channels arrive in the same cycle

Behaviour:
- Reset (async assert, sync release): state IDLE; all outputs 0; t_buf counter 0; previous-sample SCL/SDA regs 1; previous f_ref reg 0.
- START on channel x: prev_sda=1, sda=0, scl=1 and prev_scl=1, sampled on i_clk.
- STOP on channel x: prev_sda=0, sda=1, scl=1 and prev_scl=1.
- All outputs are registered; a decision takes effect one cycle after the qualifying sample.
- State IDLE:
  - START on a only, and i_chb_idle=1 -> OWN_A; o_cha_ismst=1, o_start pulse.
  - START on b only, and i_cha_idle=1 -> OWN_B; symmetric.
  - START on both in the same cycle -> grant per PRIORITY_A; o_tie pulse.
  - START while the other channel is not idle -> ignored; stay IDLE.
- State OWN_A / OWN_B:
  - STOP on the owner channel, or owner idle rising (timeout) -> HOLDOFF; ismst cleared; o_txn_done pulse.
  - i_violation or i_stuck -> DISCONNECT; ismst cleared; o_disconnect=1.
  - Repeated START on the owner channel -> stay in the state, no pulse.
  - START on the non-owner channel -> ignored.
  - If violation/stuck and STOP occur in the same cycle, DISCONNECT wins.
- State DISCONNECT: o_disconnect held 1. When i_cha_idle=1, i_chb_idle=1 and i_stuck=0 -> HOLDOFF; o_disconnect cleared.
- State HOLDOFF:
  - The counter increments on each f_ref rising edge while all four SCL/SDA inputs are 1.
  - Any input 0 clears the counter.
  - Counter == F_REF_T_BUF -> IDLE, counter cleared.
  - The counter saturates and never wraps.
  - STARTs are ignored during HOLDOFF.
  - i_stuck=1 -> DISCONNECT.
- Invariants: o_cha_ismst & o_chb_ismst is never 1; ismst is never 1 while o_disconnect=1.

Optional Feature:
I2C_PASSTHRU_ARB_STATS_EN:
- When defined, adds ports i_stats_clr (in,1), o_grant_cnt_a (out,16) and o_grant_cnt_b (out,16).
- Each counter increments on a grant to its channel, saturates at 16'hFFFF, resets to 0, and is cleared synchronously by i_stats_clr. If clear and increment coincide, clear wins.
- When undefined: no ports, no counters, arbitration behaviour identical.

Decomposition:
- Shared package i2c_passthru_pkg: arbiter state encoding (IDLE, OWN_A, OWN_B, DISCONNECT, HOLDOFF) and the STATS counter width constant (16).
- Natural sub-module i2c_passthru_startstop_det: per-channel prev-sample regs plus START/STOP pulse generation, instantiated twice.

Test Plan:
- Reset mid-OWN_A (rstn low 1 cycle) -> all outputs 0 immediately; state IDLE after release.
- START on a, both idle -> o_cha_ismst=1 and o_start pulse one cycle later; 8 bits then STOP -> o_txn_done pulse, ismst=0; IDLE only after 38 f_ref edges of all-high lines.
- Same-cycle START on a and b, PRIORITY_A=0 -> o_chb_ismst=1, o_tie pulse; a's bus not granted.
- OWN_B, i_violation asserted together with STOP -> o_disconnect=1 (not HOLDOFF); after both idle, HOLDOFF then IDLE.
- HOLDOFF with SDA a pulsed low at edge 30 -> counter restarts; IDLE reached only after 38 further clean edges.
- With STATS_EN: 3 grants to a, 1 to b -> counts 3/1; i_stats_clr together with a grant -> count 0.
